// File: rtl/barrel_pkg.sv
// barrel_pkg: op codes, op type and shift-width helper for barrel_shift_pipe
package barrel_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_SLL  = 3'b000;
  localparam op_t OP_SRL  = 3'b001;
  localparam op_t OP_SRA  = 3'b010;
  localparam op_t OP_ROL  = 3'b011;
  localparam op_t OP_ROR  = 3'b100;
  localparam op_t OP_PASS = 3'b101;
  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one pipeline stage shifting by STEP when its amount bit is set
// BARREL_ROTATE_EN adds rotate muxes; otherwise ROL/ROR fall back to SLL/SRL.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_amt,
  input  logic [2:0]       up_op,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             stall_next,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [SHW-1:0]   amt,
  output logic [2:0]       op,
  output logic [TAG_W-1:0] tag
);
  localparam int K = $clog2(STEP);
  logic [WIDTH-1:0] sll, srl, sra, rol, ror, sh;
  logic stall;
  assign sll = up_data << STEP;
  assign srl = up_data >> STEP;
  assign sra = $signed(up_data) >>> STEP;
`ifdef BARREL_ROTATE_EN
  assign rol = sll | (up_data >> (WIDTH - STEP));
  assign ror = srl | (up_data << (WIDTH - STEP));
`else
  assign rol = sll;
  assign ror = srl;
`endif
  assign sh = !up_amt[K]        ? up_data :
              up_op == OP_SLL   ? sll :
              up_op == OP_SRL   ? srl :
              up_op == OP_SRA   ? sra :
              up_op == OP_ROL   ? rol :
              up_op == OP_ROR   ? ror : up_data;
  assign stall = valid && stall_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= OP_SLL;
      tag   <= '0;
    end else if (!stall) begin
      valid <= up_valid;
      data  <= sh;
      amt   <= up_amt;
      op    <= up_op;
      tag   <= up_tag;
    end
  end
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined shifter, one stage per amount bit, valid/ready backpressure
// BARREL_ROTATE_EN enables true rotates for ROL/ROR.
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = shw_of(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  logic [SHW:0]     v;
  logic [WIDTH-1:0] d [SHW+1];
  logic [SHW-1:0]   a [SHW+1];
  logic [2:0]       o [SHW+1];
  logic [TAG_W-1:0] t [SHW+1];
  logic [SHW-1:0]   sn;
  logic             unused_tail;
  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign o[0] = in_op;
  assign t[0] = in_tag;
  genvar k;
  for (k = 0; k < SHW; k++) begin : g_stage
    // a stage is blocked only if every stage downstream of it is full and the sink stalls
    if (k == SHW - 1) begin : g_last
      assign sn[k] = !out_ready;
    end else begin : g_mid
      assign sn[k] = !out_ready && &v[SHW:k+2];
    end
    barrel_stage #(
      .WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W), .STEP(1 << k)
    ) u_stage (
      .clk(clk), .rst(rst),
      .up_valid(v[k]), .up_data(d[k]), .up_amt(a[k]), .up_op(o[k]), .up_tag(t[k]),
      .stall_next(sn[k]),
      .valid(v[k+1]), .data(d[k+1]), .amt(a[k+1]), .op(o[k+1]), .tag(t[k+1])
    );
  end
  assign in_ready    = !(!out_ready && &v[SHW:1]);
  assign out_valid   = v[SHW];
  assign out_data    = d[SHW];
  assign out_tag     = t[SHW];
  assign unused_tail = ^{a[SHW], o[SHW]};
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: scoreboard bench with a behavioural shift model
module tb_barrel_shift_pipe;
  import barrel_pkg::*;
  localparam int S = 5;
`ifdef BARREL_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h80000000;
  localparam logic [31:0] ROL_EXP = 32'h00000018;
`else
  localparam logic [31:0] ROR_EXP = 32'h00000000;
  localparam logic [31:0] ROL_EXP = 32'h00000010;
`endif
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] in_data = 0, out_data;
  logic [4:0] in_amt = 0;
  logic [2:0] in_op = 0;
  logic [3:0] in_tag = 0, out_tag;
  logic v8 = 0, r8, ov8;
  logic [7:0] d8 = 0, od8;
  logic [2:0] a8 = 0, o8 = 0;
  logic [3:0] t8 = 0, ot8;
  logic rand_rdy = 0, force_rdy = 1, saw_full = 0;
  int total = 0, bad = 0, cyc = 0, occ = 0;
  typedef struct {logic [31:0] data; logic [3:0] tag; int acc; bit lat;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_shift_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag));

  barrel_shift_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_data(d8),
    .in_amt(a8), .in_op(o8), .in_tag(t8), .out_valid(ov8),
    .out_ready(1'b1), .out_data(od8), .out_tag(ot8));

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // reference: whole-amount shifts on a zero-extended, masked operand
  function automatic logic [31:0] ref_model(int w, logic [31:0] x0, int a, logic [2:0] op);
    logic [63:0] m, x, r;
    m = (64'd1 << w) - 1;
    x = {32'd0, x0} & m;
    case (op)
      3'd0: r = x << a;
      3'd1: r = x >> a;
      3'd2: r = (x >> a) | (x[w-1] ? (m & ~(m >> a)) : 64'd0);
`ifdef BARREL_ROTATE_EN
      3'd3: r = (x << a) | (x >> (w - a));
      3'd4: r = (x >> a) | (x << (w - a));
`else
      3'd3: r = x << a;
      3'd4: r = x >> a;
`endif
      default: r = x;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  initial forever begin
    @(posedge clk);
    #2 out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  initial begin : monitor
    logic hold;
    logic [31:0] hd;
    logic [3:0] ht;
    exp_t e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        occ = 0;
      end else begin
        check("in_ready", in_ready, !(occ == S && !out_ready));
        if (occ == S && !out_ready) saw_full = 1;
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hd);
          check("hold_tag", out_tag, ht);
        end
        hold = out_valid && !out_ready;
        hd = out_data;
        ht = out_tag;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got %h want none", out_data);
          end else begin
            e = q.pop_front();
            check("data", out_data, e.data);
            check("tag", out_tag, e.tag);
            if (e.lat) check("latency", cyc - e.acc, S);
          end
        end
        if (in_valid && in_ready) occ++;
        if (out_valid && out_ready) occ--;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] dd, logic [4:0] aa, logic [2:0] oo, logic [3:0] tt,
                      logic [31:0] ee, bit lat);
    exp_t e;
    int n = 0;
    in_valid = 1; in_data = dd; in_amt = aa; in_op = oo; in_tag = tt;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) break;
    end
    if (n > 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end else begin
      e.data = ee; e.tag = tt; e.acc = cyc; e.lat = lat;
      q.push_back(e);
    end
    sync();
    in_valid = 0;
  endtask

  task automatic send_rand(logic [3:0] tt);
    logic [31:0] dd;
    logic [4:0] aa;
    logic [2:0] oo;
    dd = $urandom;
    aa = 5'($urandom_range(0, 31));
    oo = 3'($urandom_range(0, 7));
    send(dd, aa, oo, tt, ref_model(32, dd, int'(aa), oo), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending got %0d want 0", q.size());
      q.delete();
    end
    sync();
  endtask

  task automatic test8(logic [7:0] dd, logic [2:0] aa, logic [2:0] oo, logic [7:0] ee);
    int acc, n = 0;
    v8 = 1; d8 = dd; a8 = aa; o8 = oo; t8 = 4'(aa + 3'd1);
    @(negedge clk);
    check("w8_ready", r8, 1);
    acc = cyc;
    sync();
    v8 = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8_latency", cyc - acc, 3);
    check("w8_data", od8, ee);
    check("w8_tag", ot8, t8);
    sync();
  endtask

  initial begin
    logic [7:0] r8d;
    logic [2:0] r8a, r8o;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_ready", in_ready, 1);
    sync();
    send(32'h00400000, 1, OP_SLL, 3, 32'h00800000, 1);
    drain();
    send(32'h80000000, 31, OP_SRA, 1, 32'hFFFFFFFF, 1);
    send(32'h80000000, 31, OP_SRL, 2, 32'h00000001, 0);
    send(32'h80000000, 31, OP_SLL, 6, 32'h00000000, 0);
    for (int i = 0; i < 8; i++) send(32'hDEADBEEF, 0, 3'(i), 4'(i), 32'hDEADBEEF, 0);
    send(32'h00000001, 1, OP_ROR, 4, ROR_EXP, 0);
    send(32'h80000001, 4, OP_ROL, 5, ROL_EXP, 0);
    drain();
    fork
      for (int i = 0; i < 8; i++) send_rand(4'(i));
      begin
        repeat (6) @(posedge clk);
        #1 force_rdy = 0;
        repeat (4) @(posedge clk);
        #1 force_rdy = 1;
      end
    join
    drain();
    check("full_seen", saw_full, 1);
    for (int i = 0; i < 3; i++) send_rand(4'(i + 9));
    rst = 1;
    in_valid = 1; in_data = 32'h12345678; in_amt = 2; in_op = OP_SLL; in_tag = 4'hF;
    q.delete();
    sync();
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    check("flush_data", out_data, 0);
    check("flush_tag", out_tag, 0);
    check("flush_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check("flush_valid", out_valid, 0);
      @(negedge clk);
    end
    sync();
    send(32'h0000F00D, 4, OP_SLL, 7, 32'h000F00D0, 1);
    drain();
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) sync();
      send_rand(4'(i));
    end
    rand_rdy = 0;
    sync();
    drain();
    test8(8'h81, 3'd7, OP_SLL, 8'h80);
    test8(8'h5A, 3'd3, 3'b101, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      r8d = 8'($urandom);
      r8a = 3'($urandom_range(0, 7));
      r8o = 3'($urandom_range(0, 7));
      test8(r8d, r8a, r8o, 8'(ref_model(8, {24'd0, r8d}, int'(r8a), r8o)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational left barrel shifter.
- Supports left/right logical, arithmetic-right and (optionally) rotate operations on a WIDTH-bit operand.
- One registered stage per shift-amount bit, with a valid/ready handshake and full backpressure.
- Sits between the operand register file and the ALU result mux; an opaque tag travels with each operation.

Parameters:
- WIDTH, 32: operand width; power of 2, at least 2.
- SHW, $clog2(WIDTH): shift-amount width; derived, never overridden.
- TAG_W, 4: width of the sideband tag carried with each operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation present
- in_ready  out  1  block accepts the operation this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift amount
- in_op  in  3  operation code
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Op codes:
  - 000 SLL
  - 001 SRL
  - 010 SRA (fills with the sign bit)
  - 011 ROL
  - 100 ROR
  - 101–111 PASS (out_data = in_data)
- Pipeline structure:
  - SHW stages. Stage k conditionally shifts or rotates by 2^k when amt[k]=1, then registers data, amt, op, tag and a valid bit.
  - Stage SHW-1 drives the out_* ports.
- Amount rules:
  - in_amt=0 returns in_data unchanged for every op.
  - Amounts are never reduced modulo anything beyond SHW bits.
  - SLL/SRL by WIDTH-1 leaves at most 1 bit.
- Transfer rule: a transfer occurs on a clock edge when valid && ready.
- Latency: SHW cycles from input transfer to out_valid with no stall (5 for WIDTH=32). Throughput is 1 operation/cycle.
- Stall chain:
  - stall_last = v_last && !out_ready.
  - stall_k = v_k && stall_{k+1}.
  - A stage loads from upstream when not stalled. When it is not stalled and receives nothing, its valid clears.
  - in_ready = !stall_0. This is combinational from out_ready through the chain.
- Ordering and capacity:
  - Results leave in acceptance order; no operation is ever dropped or duplicated.
  - Maximum occupancy is SHW operations. When all stages are full and out_ready=0, in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag hold stable.
- Reset:
  - rst=1 clears all stage valid bits and zeroes all stage data and tags.
  - In the cycle after reset: out_valid=0, out_data=0, out_tag=0, in_ready=1.
  - Reset mid-operation discards all in-flight operations. An input presented during the reset cycle is not accepted.
- No internal state beyond the stage registers; no FSM besides the per-stage valid bits.

Optional Feature:
- Macro: BARREL_ROTATE_EN.
- Defined: ROL and ROR rotate; bits shifted out re-enter at the opposite end.
- Undefined: ROL behaves as SLL and ROR as SRL. No rotate muxes are synthesised. Op codes and port list are unchanged.

Decomposition:
- Package barrel_pkg holds:
  - op-code localparams OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_PASS;
  - the 3-bit op typedef;
  - a function computing SHW from WIDTH.
- Sub-module barrel_stage (parameters WIDTH, SHW, TAG_W, STEP):
  - one conditional shift by STEP, plus its registers and valid/stall logic;
  - instantiated SHW times in a generate loop with STEP=2^k.

Test Plan:
- Single SLL: in_data=0x00400000, in_amt=1, op=SLL, tag=3, out_ready=1 -> out_valid exactly 5 cycles later, out_data=0x00800000, out_tag=3.
- Sign fill and zero amount: SRA 0x80000000 by 31 -> 0xFFFFFFFF. SRL 0x80000000 by 31 -> 0x00000001. Any op with amt=0 on 0xDEADBEEF -> 0xDEADBEEF.
- Rotate under the macro: ROR 0x00000001 by 1 -> 0x80000000 and ROL 0x80000001 by 4 -> 0x00000018 with BARREL_ROTATE_EN defined. Without it the same stimuli give 0x00000000 and 0x00000010.
- Backpressure: stream 8 back-to-back operations with tags 0–7 and hold out_ready=0 for cycles 6–9. Require:
  - in_ready=0 once 5 operations are held;
  - stable outputs while stalled;
  - all 8 results in tag order, no loss.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid stays 0 thereafter. The next operation returns after exactly 5 cycles with the correct result.
- WIDTH=8 instance: SLL 0x81 by 7 -> 0x80 after 3 cycles, and PASS op 101 -> input unchanged.
